// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one fifo write port among NUM_REQ producers
// Optional burst lock (grant held until req_last or MAX_BURST words) enabled by GRANT_LOCK_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, next_state;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   base;
  logic [GW-1:0]   winner;
  logic            found;
  logic            accept;
  logic            rel;

  // Rotation starts after the current owner in GRANT, so the owner only re-wins when alone.
  always_comb begin
    base   = (state == GRANT) ? grant_id : last_grant;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = int'(base) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx[GW-1:0]]) begin
        found  = 1'b1;
        winner = idx[GW-1:0];
      end
    end
  end

  assign accept = (state == GRANT) && req_valid[grant_id] && !fifo_full;

`ifdef GRANT_LOCK_EN
  localparam int BW = $clog2(MAX_BURST) + 1;
  logic [BW-1:0] burst_cnt;

  assign rel = accept && (req_last[grant_id] || (burst_cnt == BW'(MAX_BURST - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (state != GRANT || rel) begin
      burst_cnt <= '0;
    end else if (accept) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign rel = accept || !req_valid[grant_id];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        if (found) grant_id <= winner;
      end else if (rel) begin
        last_grant <= grant_id;
        if (found) grant_id <= winner;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = GRANT;
      GRANT:   if (rel && !found) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    busy         = (state == GRANT);
    fifo_data_in = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    if (state == GRANT) begin
      req_ready[grant_id] = !fifo_full;
      fifo_wr_en          = accept;
    end
  end

endmodule
